// File: rtl/mem_ctrl_pkg.sv
// Shared encodings and default sizes for the memory access controller.
// The owner encoding doubles as the arbiter's grant index.
package mem_ctrl_pkg;

    localparam int DEF_AW   = 8;
    localparam int DEF_DW   = 8;
    localparam int DEF_WAIT = 2;
    localparam int DEF_CW   = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter: on a tie the port that did not
// finish the previous access wins.
module rr_arb2
    import mem_ctrl_pkg::*;
(
    input  logic [1:0] i_req,
    input  owner_t     i_last_owner,
    output logic       o_gnt_valid,
    output owner_t     o_gnt_owner
);

    always_comb begin
        o_gnt_valid = |i_req;
        o_gnt_owner = OWN_CPU;
        case (i_req)
            2'b10:   o_gnt_owner = OWN_DMA;
            2'b11:   o_gnt_owner = (i_last_owner == OWN_CPU) ? OWN_DMA : OWN_CPU;
            default: o_gnt_owner = OWN_CPU;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Shares one memory between the CPU and a DMA port, one access at a
// time, with WAIT wait states and a one-cycle completion pulse.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int AW   = DEF_AW,
    parameter int DW   = DEF_DW,
    parameter int WAIT = DEF_WAIT,
    parameter int CW   = DEF_CW
) (
    input  logic          CLK,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_rnw,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          MFC,
    output logic [DW-1:0] cpu_rdata,
    input  logic          dma_req,
    input  logic          dma_rnw,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_ack,
    output logic [DW-1:0] dma_rdata,
    output logic          dma_gnt,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    state_t        r_state;
    state_t        w_next;
    owner_t        r_owner;
    owner_t        r_last;
    logic          r_rnw;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_cpu_rdata;
    logic [DW-1:0] r_dma_rdata;
    logic [CW-1:0] r_cnt;
    logic          w_gnt_valid;
    owner_t        w_gnt_owner;
    logic          w_cnt_zero;

    assign w_cnt_zero = (r_cnt == '0);

    rr_arb2 u_arb (
        .i_req        ({dma_req, cpu_req}),
        .i_last_owner (r_last),
        .o_gnt_valid  (w_gnt_valid),
        .o_gnt_owner  (w_gnt_owner)
    );

    always_ff @(posedge CLK) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_gnt_valid) w_next = ACCESS;
            ACCESS:  if (w_cnt_zero) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Port inputs are sampled only at grant; later changes are ignored.
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_owner     <= OWN_CPU;
            r_last      <= OWN_DMA;
            r_rnw       <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_cnt       <= '0;
            r_cpu_rdata <= '0;
            r_dma_rdata <= '0;
        end else if (r_state == IDLE && w_gnt_valid) begin
            r_owner <= w_gnt_owner;
            r_cnt   <= CW'(WAIT);
            if (w_gnt_owner == OWN_DMA) begin
                r_rnw   <= dma_rnw;
                r_addr  <= dma_addr;
                r_wdata <= dma_wdata;
            end else begin
                r_rnw   <= cpu_rnw;
                r_addr  <= cpu_addr;
                r_wdata <= cpu_wdata;
            end
        end else if (r_state == ACCESS) begin
            if (w_cnt_zero) begin
                r_last <= r_owner;
                if (r_rnw && r_owner == OWN_CPU) r_cpu_rdata <= mem_rdata;
                if (r_rnw && r_owner == OWN_DMA) r_dma_rdata <= mem_rdata;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        dma_gnt   = 1'b0;
        MFC       = 1'b0;
        dma_ack   = 1'b0;
        case (r_state)
            ACCESS: begin
                mem_en    = 1'b1;
                mem_we    = !r_rnw;
                mem_addr  = r_addr;
                mem_wdata = r_wdata;
                dma_gnt   = (r_owner == OWN_DMA);
            end
            DONE: begin
                dma_gnt = (r_owner == OWN_DMA);
                MFC     = (r_owner == OWN_CPU);
                dma_ack = (r_owner == OWN_DMA);
            end
            default: ;
        endcase
    end

    assign cpu_rdata = r_cpu_rdata;
    assign dma_rdata = r_dma_rdata;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench: two controllers (WAIT=2 and WAIT=0), each with its
// own memory model; completions are checked against queued expectations.
module tb_mem_access_ctrl;

    localparam int W = 2;

    typedef struct {
        bit         dma;
        bit         rnw;
        logic [7:0] rd;
        int         cyc;
    } exp_t;

    logic CLK = 1'b0;
    logic reset;
    int   cyc;
    int   n_chk = 0;
    int   n_err = 0;
    exp_t q0[$];
    exp_t q1[$];

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    logic       a_cpu_req, a_cpu_rnw, a_dma_req, a_dma_rnw;
    logic [7:0] a_cpu_addr, a_cpu_wdata, a_dma_addr, a_dma_wdata;
    logic       a_mfc, a_ack, a_gnt, a_en, a_we;
    logic [7:0] a_crd, a_drd, a_addr, a_wdata, a_rdata;
    logic [7:0] mem0 [256];
    int         wr0 = 0;

    logic       b_cpu_req, b_cpu_rnw, b_dma_req, b_dma_rnw;
    logic [7:0] b_cpu_addr, b_cpu_wdata, b_dma_addr, b_dma_wdata;
    logic       b_mfc, b_ack, b_gnt, b_en, b_we;
    logic [7:0] b_crd, b_drd, b_addr, b_wdata, b_rdata;
    logic [7:0] mem1 [256];

    mem_access_ctrl #(.WAIT(W)) dut0 (
        .CLK(CLK), .reset(reset),
        .cpu_req(a_cpu_req), .cpu_rnw(a_cpu_rnw),
        .cpu_addr(a_cpu_addr), .cpu_wdata(a_cpu_wdata),
        .MFC(a_mfc), .cpu_rdata(a_crd),
        .dma_req(a_dma_req), .dma_rnw(a_dma_rnw),
        .dma_addr(a_dma_addr), .dma_wdata(a_dma_wdata),
        .dma_ack(a_ack), .dma_rdata(a_drd), .dma_gnt(a_gnt),
        .mem_en(a_en), .mem_we(a_we), .mem_addr(a_addr),
        .mem_wdata(a_wdata), .mem_rdata(a_rdata)
    );

    mem_access_ctrl #(.WAIT(0)) dut1 (
        .CLK(CLK), .reset(reset),
        .cpu_req(b_cpu_req), .cpu_rnw(b_cpu_rnw),
        .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata),
        .MFC(b_mfc), .cpu_rdata(b_crd),
        .dma_req(b_dma_req), .dma_rnw(b_dma_rnw),
        .dma_addr(b_dma_addr), .dma_wdata(b_dma_wdata),
        .dma_ack(b_ack), .dma_rdata(b_drd), .dma_gnt(b_gnt),
        .mem_en(b_en), .mem_we(b_we), .mem_addr(b_addr),
        .mem_wdata(b_wdata), .mem_rdata(b_rdata)
    );

    assign a_rdata = mem0[a_addr];
    assign b_rdata = mem1[b_addr];

    always @(posedge CLK) begin
        if (a_en && a_we) begin
            mem0[a_addr] <= a_wdata;
            wr0 <= wr0 + 1;
        end
        if (b_en && b_we) mem1[b_addr] <= b_wdata;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Scoreboard monitors: every completion pulse must match the queue head.
    always @(negedge CLK) begin
        exp_t e;
        if (a_mfc || a_ack) begin
            chk("a_single_ack", {31'd0, a_mfc && a_ack}, 32'd0);
            if (q0.size() == 0) begin
                chk("a_unexpected_ack", {30'd0, a_ack, a_mfc}, 32'd0);
            end else begin
                e = q0.pop_front();
                chk("a_ack_owner", {30'd0, a_ack, a_mfc}, e.dma ? 32'd2 : 32'd1);
                chk("a_ack_cycle", cyc, e.cyc);
                if (e.rnw) chk("a_rdata", e.dma ? a_drd : a_crd, e.rd);
            end
        end
    end

    always @(negedge CLK) begin
        exp_t e;
        if (b_mfc || b_ack) begin
            if (q1.size() == 0) begin
                chk("b_unexpected_ack", {30'd0, b_ack, b_mfc}, 32'd0);
            end else begin
                e = q1.pop_front();
                chk("b_ack_owner", {30'd0, b_ack, b_mfc}, e.dma ? 32'd2 : 32'd1);
                chk("b_ack_cycle", cyc, e.cyc);
                if (e.rnw) chk("b_rdata", e.dma ? b_drd : b_crd, e.rd);
            end
        end
    end

    task automatic push0(input bit dma, input bit rnw, input logic [7:0] rd, input int c);
        exp_t e;
        e.dma = dma; e.rnw = rnw; e.rd = rd; e.cyc = c;
        q0.push_back(e);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_ctrl"}, {27'd0, a_mfc, a_ack, a_gnt, a_en, a_we}, 32'd0);
        chk({nm, "_data"}, {a_addr, a_wdata, a_crd, a_drd}, 32'd0);
    endtask

    // One transaction on dut0, started at posedge+1 while IDLE.
    task automatic txn(input bit dma, input bit rnw, input logic [7:0] addr,
                       input logic [7:0] wd, input logic [7:0] rd, input bit scr);
        int  c;
        bit  acc;
        c = cyc;
        if (dma) begin
            a_dma_req = 1; a_dma_rnw = rnw; a_dma_addr = addr; a_dma_wdata = wd;
        end else begin
            a_cpu_req = 1; a_cpu_rnw = rnw; a_cpu_addr = addr; a_cpu_wdata = wd;
        end
        push0(dma, rnw, rd, c + W + 2);
        for (int k = 0; k <= W + 2; k++) begin
            @(negedge CLK);
            if (scr && k == 1) begin
                if (dma) begin a_dma_addr = 8'h99; a_dma_wdata = 8'hEE; end
                else     begin a_cpu_addr = 8'h99; a_cpu_wdata = 8'hEE; end
            end
            acc = (k >= 1 && k <= W + 1);
            chk("mem_en", {31'd0, a_en}, {31'd0, acc});
            chk("mem_we", {31'd0, a_we}, {31'd0, acc && !rnw});
            chk("dma_gnt", {31'd0, a_gnt}, {31'd0, dma && k >= 1});
            if (acc) chk("mem_addr", {24'd0, a_addr}, {24'd0, addr});
            if (acc && !rnw) chk("mem_wdata", {24'd0, a_wdata}, {24'd0, wd});
        end
        @(posedge CLK); #1;
        if (dma) a_dma_req = 0;
        else     a_cpu_req = 0;
    endtask

    initial begin
        int c;
        int w;
        exp_t e;
        for (int i = 0; i < 256; i++) begin
            mem0[i] <= 8'h00;
            mem1[i] <= 8'h00;
        end
        mem0[8'h10] <= 8'h5A;
        mem1[8'h7F] <= 8'hC3;
        reset = 1;
        {a_cpu_req, a_cpu_rnw, a_dma_req, a_dma_rnw} = '0;
        {a_cpu_addr, a_cpu_wdata, a_dma_addr, a_dma_wdata} = '0;
        {b_cpu_req, b_cpu_rnw, b_dma_req, b_dma_rnw} = '0;
        {b_cpu_addr, b_cpu_wdata, b_dma_addr, b_dma_wdata} = '0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        @(negedge CLK);
        chk_zero("reset");
        chk("b_reset", {26'd0, b_mfc, b_ack, b_gnt, b_en, b_we, |b_drd}, 32'd0);
        @(posedge CLK); #1;
        reset = 0;

        // CPU read with the address port scrambled mid-access
        txn(0, 1, 8'h10, 8'h00, 8'h5A, 1);
        chk("cpu_rd_hold", {24'd0, a_crd}, 32'h5A);

        // DMA write then CPU read-back
        txn(1, 0, 8'h20, 8'h33, 8'h00, 0);
        chk("mem_20", {24'd0, mem0[8'h20]}, 32'h33);
        chk("cpu_rd_after_wr", {24'd0, a_crd}, 32'h5A);
        chk("dma_rd_after_wr", {24'd0, a_drd}, 32'h00);
        txn(0, 1, 8'h20, 8'h00, 8'h33, 0);

        // Both ports held high from reset: grants must alternate
        reset = 1;
        a_cpu_req = 1; a_cpu_rnw = 1; a_cpu_addr = 8'h10;
        a_dma_req = 1; a_dma_rnw = 1; a_dma_addr = 8'h20;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        reset = 0;
        c = cyc;
        for (int i = 0; i < 4; i++)
            push0(i[0], 1, i[0] ? 8'h33 : 8'h5A, c + 4 + 5 * i);
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            chk("rr_gnt", {31'd0, a_gnt}, {31'd0, ((k / 5) % 2 == 1) && (k % 5 >= 1)});
        end
        @(posedge CLK); #1;
        a_cpu_req = 0; a_dma_req = 0;

        // Reset in the second ACCESS cycle of a CPU write
        a_cpu_req = 1; a_cpu_rnw = 0; a_cpu_addr = 8'h40; a_cpu_wdata = 8'hAB;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        reset = 1; a_cpu_req = 0;
        @(posedge CLK); #1;
        reset = 0;
        @(negedge CLK);
        chk_zero("mid_reset");
        w = wr0;
        repeat (3) @(negedge CLK);
        chk("no_write_after_reset", wr0, w);
        @(posedge CLK); #1;
        txn(0, 1, 8'h10, 8'h00, 8'h5A, 0);

        // WAIT=0 controller: single access cycle
        c = cyc;
        b_dma_req = 1; b_dma_rnw = 1; b_dma_addr = 8'h7F;
        e.dma = 1; e.rnw = 1; e.rd = 8'hC3; e.cyc = c + 2;
        q1.push_back(e);
        for (int k = 0; k <= 2; k++) begin
            @(negedge CLK);
            chk("b_mem_en", {31'd0, b_en}, {31'd0, k == 1});
            chk("b_dma_gnt", {31'd0, b_gnt}, {31'd0, k >= 1});
        end
        @(posedge CLK); #1;
        b_dma_req = 0;
        @(negedge CLK);
        chk("b_dma_rd_hold", {24'd0, b_drd}, 32'hC3);

        repeat (4) @(negedge CLK);
        chk("a_pending", q0.size(), 0);
        chk("b_pending", q1.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Memory access sequencer and two-way arbiter between the control unit (CPU port) and a DMA/IO requester. It shares one 8-bit memory, inserts a fixed number of wait states, and returns completion as a one-cycle MFC pulse to the CPU, which feeds the control unit's WMFC clock gating, or as dma_ack to the DMA port. One transaction is in flight at a time.

Parameters:
AW, 8, address width
DW, 8, data width
WAIT, 2, wait-state cycles added to each access; 0 is legal and gives a single access cycle
CW, 3, width of the wait counter; must satisfy 2^CW > WAIT

Ports:
CLK  in  1  system clock; all state updates on its rising edge
reset  in  1  synchronous, active-high reset
cpu_req  in  1  CPU access request; held until MFC is sampled
cpu_rnw  in  1  1 = read, 0 = write
cpu_addr  in  AW  CPU address
cpu_wdata  in  DW  CPU write data
MFC  out  1  memory-function-complete pulse to the CPU
cpu_rdata  out  DW  CPU read data
dma_req  in  1  DMA access request; held until dma_ack is sampled
dma_rnw  in  1  1 = read, 0 = write
dma_addr  in  AW  DMA address
dma_wdata  in  DW  DMA write data
dma_ack  out  1  completion pulse to the DMA port
dma_rdata  out  DW  DMA read data
dma_gnt  out  1  high while the DMA owns the memory
mem_en  out  1  memory enable
mem_we  out  1  memory write enable
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data

Behaviour:
- Reset (synchronous, active-high):
  - FSM goes to IDLE; wait counter = 0; last_owner = DMA, so the CPU wins the first tie.
  - All outputs are 0, including cpu_rdata and dma_rdata.
  - An in-flight transaction is abandoned: no MFC and no dma_ack is issued, and memory is not written after reset.
- FSM states: IDLE -> ACCESS -> DONE -> IDLE.
- IDLE:
  - If neither request is high, stay in IDLE.
  - If exactly one request is high, grant it.
  - If both are high, grant the owner that is not last_owner (round robin).
  - On grant: latch owner, rnw, addr and wdata from the winning port; set counter = WAIT; go to ACCESS.
- ACCESS:
  - mem_en = 1, mem_we = !rnw_latched, and mem_addr/mem_wdata come from the latched values.
  - dma_gnt = 1 when owner = DMA.
  - When counter = 0: capture mem_rdata into the owner's rdata register (reads only), update last_owner, and go to DONE. Otherwise decrement the counter.
  - The ACCESS state lasts WAIT+1 cycles.
- DONE:
  - mem_en = 0; dma_gnt stays 1 if owner = DMA.
  - For one cycle, MFC = 1 if owner = CPU, otherwise dma_ack = 1. Then go to IDLE.
- Handshake rules:
  - A requester deasserts req on the edge at which it samples its ack. IDLE therefore sees fresh requests only.
  - Port inputs that change after grant are ignored.
- Latency: req high in IDLE at cycle 0 -> ACCESS in cycles 1..WAIT+1 -> ack in cycle WAIT+2. Back-to-back throughput is one access per WAIT+3 cycles.
- Read data:
  - cpu_rdata and dma_rdata are valid from the ack cycle onward.
  - They are held until the next read by the same port; writes leave them unchanged.
- MFC and dma_ack are never high in the same cycle and are never high outside DONE.
- Arbitration is starvation-free: with both requests continuously high, grants alternate CPU, DMA, CPU, ...

Decomposition:
- Package mem_ctrl_pkg holds:
  - state encoding (IDLE = 0, ACCESS = 1, DONE = 2, 2-bit);
  - owner encoding (OWN_CPU = 0, OWN_DMA = 1);
  - default AW, DW and WAIT constants.
- Sub-module rr_arb2: a combinational two-input round-robin arbiter. Inputs: req[1:0] and last_owner. Outputs: gnt_valid and gnt_owner. The top level holds the FSM, counter, latches and rdata registers.

Test Plan:
- Reset, then CPU read addr 0x10 (mem holds 0x5A), WAIT=2 -> mem_en high in cycles 1-3, MFC pulse in cycle 4, cpu_rdata = 0x5A, dma_ack stays 0.
- DMA write 0x33 to 0x20, then CPU read 0x20 -> dma_gnt high in cycles 1-4, dma_ack in cycle 4, mem_we high only in DMA ACCESS cycles, cpu_rdata = 0x33.
- cpu_req and dma_req both held high from reset for 4 transactions -> grant order CPU, DMA, CPU, DMA; MFC and dma_ack pulses alternate every 5 cycles.
- reset asserted in the second ACCESS cycle of a CPU write -> next cycle is IDLE with all outputs 0, no MFC, memory is not written after reset, and the next transaction completes normally.
- WAIT=0 build: DMA read of 0x7F holding 0xC3 -> mem_en high for exactly cycle 1, dma_ack in cycle 2, dma_rdata = 0xC3.
- cpu_addr changed from 0x10 to 0x99 while ACCESS is in progress -> mem_addr stays 0x10 throughout.
